// File: rtl/mips_muldiv_seq_pkg.sv
// Shared types for the sequential MIPS HI/LO multiply/divide unit.
package mips_md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } t_md_op;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } t_md_state;

  function automatic logic md_is_iterative(input t_md_op op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_seq_if.sv
// CPU-side request/result bundle of the multiply/divide unit.
interface mips_muldiv_seq_if #(parameter int WIDTH = 32);
  import mips_md_pkg::*;

  logic             clock_enable;
  logic             start;
  t_md_op           op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output clock_enable, start, op, rs_val, rt_val,
    input  busy, done, hi, lo
  );

  modport slave (
    input  clock_enable, start, op, rs_val, rt_val,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mips_md_datapath.sv
// Iteration datapath: unsigned shift-add multiply / restoring divide on operand
// magnitudes, plus final sign correction of the result.
module mips_md_datapath
  import mips_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  t_md_op           op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // acc: product upper half / partial remainder; sh: multiplier / quotient shift register
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;

  logic             is_div_op;
  logic             signed_op;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;

  assign is_div_op = (op == MD_DIV) || (op == MD_DIVU);
  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign neg_a     = signed_op & rs_val[WIDTH-1];
  assign neg_b     = signed_op & rt_val[WIDTH-1];
  assign mag_a     = cond_neg_w(rs_val, neg_a);
  assign mag_b     = cond_neg_w(rt_val, neg_b);

  always_comb begin
    acc_d   = acc_q;
    sh_d    = sh_q;
    m_d     = m_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    sum     = '0;
    shifted = '0;
    ge      = 1'b0;
    if (load) begin
      acc_d  = '0;
      sh_d   = is_div_op ? mag_a : mag_b;
      m_d    = is_div_op ? mag_b : mag_a;
      div_d  = is_div_op;
      negq_d = neg_a ^ neg_b;
      negr_d = neg_a;
      dz_d   = (rt_val == '0);
    end else if (step) begin
      if (div_q) begin
        shifted = {acc_q, sh_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, m_q});
        acc_d   = ge ? WIDTH'(shifted - {1'b0, m_q}) : shifted[WIDTH-1:0];
        sh_d    = {sh_q[WIDTH-2:0], ge};
      end else begin
        sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        acc_d = sum[WIDTH:1];
        sh_d  = {sum[0], sh_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    sh_q   <= sh_d;
    m_q    <= m_d;
    div_q  <= div_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
    dz_q   <= dz_d;
  end

  // Divide by zero forces an all-ones quotient; the remainder path already yields rs_val.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = cond_neg_2w({acc_q, sh_q}, negq_q);
  assign quo_fix  = dz_q ? '1 : cond_neg_w(sh_q, negq_q);
  assign rem_fix  = cond_neg_w(acc_q, negr_q);
  assign res_hi   = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = div_q ? quo_fix : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/mips_muldiv_seq.sv
// Sequential MIPS HI/LO unit: one bit per cycle multiply/divide, MTHI/MTLO,
// IDLE -> RUN (WIDTH cycles) -> FIX (sign correction, HI/LO write).
module mips_muldiv_seq
  import mips_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  mips_muldiv_seq_if.slave  md
);

  t_md_state        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             load;
  logic             step;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          if (md.op == MD_MTHI) begin
            hi_d = md.rs_val;
          end else if (md.op == MD_MTLO) begin
            lo_d = md.rs_val;
          end else if (md_is_iterative(md.op)) begin
            load    = md.clock_enable;
            count_d = CNT_W'(WIDTH);
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        step    = md.clock_enable;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (md.clock_enable) begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  mips_md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .load   (load),
    .step   (step),
    .op     (md.op),
    .rs_val (md.rs_val),
    .rt_val (md.rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Scoreboard bench for mips_muldiv_seq: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_mips_muldiv_seq;
  import mips_md_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] arch_hi = '0;
  logic [31:0] arch_lo = '0;
  logic        prev_done = 1'b0;
  string       op_names[8] = '{"MULT", "MULTU", "DIV", "DIVU", "MTHI", "MTLO", "NOP6", "NOP7"};

  mips_muldiv_seq_if #(.WIDTH(W)) md ();

  mips_muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain MIPS arithmetic semantics, returns {hi, lo}
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sbv, q, r;
    case (o)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a; sbv = b;
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {arch_hi, arch_lo};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (md.done) begin
        chk("done_single_cycle", {63'b0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with no operation outstanding (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, md.hi, e.hi);
          chk({e.name, "_lo"}, md.lo, e.lo);
          chk({e.name, "_done_cycle"}, cyc, e.cyc);
          chk({e.name, "_busy_at_done"}, {63'b0, md.busy}, 64'd0);
          arch_hi = e.hi;
          arch_lo = e.lo;
        end
      end else if (md.busy) begin
        chk("hilo_stable_while_busy", {md.hi, md.lo}, {arch_hi, arch_lo});
      end
    end
    prev_done = reset ? 1'b0 : md.done;
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [63:0] r;
    int          n;
    @(negedge clk);
    n = 0;
    while (md.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (md.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1 after 200 cycles");
    end
    md.start  = 1'b1;
    md.op     = t_md_op'(o);
    md.rs_val = a;
    md.rt_val = b;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    if (o <= 3'd3) begin
      r = ref_model(o, a, b);
      sb.push_back('{r[63:32], r[31:0], cyc + LAT + stall, op_names[o]});
      chk("busy_after_start", {63'b0, md.busy}, 64'd1);
    end else begin
      if (o == 3'd4) arch_hi = a;
      if (o == 3'd5) arch_lo = a;
      chk({op_names[o], "_hilo"}, {md.hi, md.lo}, {arch_hi, arch_lo});
      chk({op_names[o], "_busy_done"}, {62'b0, md.busy, md.done}, 64'd0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners[6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 1000)) - 32'd500;
    return $urandom;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  ro;
    int          n;

    reset           = 1'b1;
    md.clock_enable = 1'b1;
    md.start        = 1'b0;
    md.op           = MD_NOP6;
    md.rs_val       = '0;
    md.rt_val       = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_hilo", {md.hi, md.lo}, 64'd0);
    chk("reset_busy_done", {62'b0, md.busy, md.done}, 64'd0);

    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    issue(3'd3, 32'h0000_0007, 32'h0000_0000, 0);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Starts while the overflow divide is running must be dropped
    repeat (4) @(negedge clk);
    md.start  = 1'b1;
    md.op     = MD_MTHI;
    md.rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    md.op     = MD_MULTU;
    md.rt_val = 32'h3;
    @(negedge clk);
    md.start = 1'b0;
    chk("busy_during_ignored_start", {63'b0, md.busy}, 64'd1);

    issue(3'd4, 32'h1234_5678, 32'h0, 0);
    issue(3'd5, 32'h9ABC_DEF0, 32'h0, 0);

    @(negedge clk);
    md.clock_enable = 1'b0;
    md.start        = 1'b1;
    md.op           = MD_MTLO;
    md.rs_val       = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    md.start        = 1'b0;
    md.clock_enable = 1'b1;
    chk("start_with_ce_low", {md.hi, md.lo}, {arch_hi, arch_lo});

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    repeat (10) @(negedge clk);
    md.clock_enable = 1'b0;
    repeat (4) @(negedge clk);
    md.clock_enable = 1'b1;

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : pick_operand();
      issue(ro, ra, rb, 0);
    end

    issue(3'd1, 32'hCAFE_F00D, 32'h1357_9BDF, 0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    arch_hi = '0;
    arch_lo = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_hilo", {md.hi, md.lo}, 64'd0);
    chk("abort_busy_done", {62'b0, md.busy, md.done}, 64'd0);
    repeat (60) @(negedge clk);

    issue(3'd3, 32'd100, 32'd7, 0);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d operations never completed", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
